// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 keypad row scanner with column synchronizer and press/release debounce
`timescale 1ns/1ps
module keypad_scanner #(
    parameter int SCAN_CYCLES     = 4,
    parameter int DEBOUNCE_CYCLES = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cols_raw,
    output logic [3:0] rows,
    output logic [3:0] key_rows,
    output logic [3:0] key_cols,
    output logic       key_valid,
    output logic       key_held
);

    localparam int DW_W = $clog2(SCAN_CYCLES);
    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(SCAN_CYCLES - 1);
    localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] ST_SCAN       = 2'd0;
    localparam logic [1:0] ST_PRESS_DB   = 2'd1;
    localparam logic [1:0] ST_HELD       = 2'd2;
    localparam logic [1:0] ST_RELEASE_DB = 2'd3;

    logic [1:0]      r_state;
    logic [3:0]      r_cols_meta;
    logic [3:0]      r_cols_s;
    logic [3:0]      r_rows;
    logic [3:0]      r_cand_rows;
    logic [3:0]      r_cand_cols;
    logic [3:0]      r_key_rows;
    logic [3:0]      r_key_cols;
    logic            r_key_valid;
    logic            r_key_held;
    logic [DW_W-1:0] r_dwell;
    logic [DB_W-1:0] r_db;

    logic [3:0] w_rows_next;
    logic       w_cols_onehot;
    logic       w_cand_match;
    logic       w_key_released;

    assign w_rows_next    = {r_rows[2:0], r_rows[3]};
    assign w_cols_onehot  = (r_cols_s != 4'd0) && ((r_cols_s & (r_cols_s - 4'd1)) == 4'd0);
    assign w_cand_match   = (r_cols_s == r_cand_cols);
    assign w_key_released = ((r_cols_s & r_key_cols) == 4'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_SCAN;
            r_cols_meta <= 4'd0;
            r_cols_s    <= 4'd0;
            r_rows      <= 4'b0001;
            r_cand_rows <= 4'd0;
            r_cand_cols <= 4'd0;
            r_key_rows  <= 4'd0;
            r_key_cols  <= 4'd0;
            r_key_valid <= 1'b0;
            r_key_held  <= 1'b0;
            r_dwell     <= '0;
            r_db        <= '0;
        end else begin
            r_cols_meta <= cols_raw;
            r_cols_s    <= r_cols_meta;
            r_key_valid <= 1'b0;
            case (r_state)
                ST_SCAN: begin
                    if (r_dwell == DWELL_LAST) begin
                        r_dwell <= '0;
                        // A single column on the driven row is a candidate; anything else is ambiguous
                        if (w_cols_onehot) begin
                            r_cand_rows <= r_rows;
                            r_cand_cols <= r_cols_s;
                            r_db        <= '0;
                            r_state     <= ST_PRESS_DB;
                        end else begin
                            r_rows <= w_rows_next;
                        end
                    end else begin
                        r_dwell <= r_dwell + DW_W'(1);
                    end
                end
                ST_PRESS_DB: begin
                    if (!w_cand_match) begin
                        r_rows  <= w_rows_next;
                        r_dwell <= '0;
                        r_state <= ST_SCAN;
                    end else if (r_db == DB_LAST) begin
                        r_key_rows  <= r_cand_rows;
                        r_key_cols  <= r_cand_cols;
                        r_key_valid <= 1'b1;
                        r_key_held  <= 1'b1;
                        r_state     <= ST_HELD;
                    end else begin
                        r_db <= r_db + DB_W'(1);
                    end
                end
                ST_HELD: begin
                    if (w_key_released) begin
                        r_db    <= '0;
                        r_state <= ST_RELEASE_DB;
                    end
                end
                default: begin
                    if (!w_key_released) begin
                        r_state <= ST_HELD;
                    end else if (r_db == DB_LAST) begin
                        r_key_held <= 1'b0;
                        r_rows     <= w_rows_next;
                        r_dwell    <= '0;
                        r_state    <= ST_SCAN;
                    end else begin
                        r_db <= r_db + DB_W'(1);
                    end
                end
            endcase
        end
    end

    assign rows      = r_rows;
    assign key_rows  = r_key_rows;
    assign key_cols  = r_key_cols;
    assign key_valid = r_key_valid;
    assign key_held  = r_key_held;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - randomized scoreboard bench for keypad_scanner against an index-based keypad model
`timescale 1ns/1ps
module tb_keypad_scanner;

    localparam int  SC = 4;
    localparam int  DB = 8;
    localparam time P  = 10;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] cols_raw = 4'd0;
    logic [3:0] rows;
    logic [3:0] key_rows;
    logic [3:0] key_cols;
    logic       key_valid;
    logic       key_held;

    keypad_scanner #(.SCAN_CYCLES(SC), .DEBOUNCE_CYCLES(DB)) dut (
        .clk(clk), .reset(reset), .cols_raw(cols_raw), .rows(rows),
        .key_rows(key_rows), .key_cols(key_cols), .key_valid(key_valid), .key_held(key_held)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] r;
        logic [3:0] c;
        time        t;
    } ev_t;

    ev_t exp_q[$];
    int  n_cmp  = 0;
    int  n_fail = 0;

    logic [15:0] pressed = 16'd0;
    int          glitch  = 0;

    // Reference keypad model: row/column kept as indices, debounce as a run length of qualifying samples
    logic [3:0] m_s1, m_s2;
    int m_mode;       // 0 scanning, 1 confirming press, 2 held, 3 confirming release
    int m_row, m_dwell, m_run;
    int cand_row, cand_col, key_row, key_col;
    bit has_key, m_held;

    function automatic int col_index(logic [3:0] v);
        int idx = 0;
        for (int i = 0; i < 4; i++) if (v[i]) idx = i;
        return idx;
    endfunction

    task automatic step_model(input bit rst, input logic [3:0] cin);
        logic [3:0] cs;
        cs   = m_s2;
        m_s2 = m_s1;
        m_s1 = cin;
        if (rst) begin
            m_s1 = 4'd0; m_s2 = 4'd0;
            m_mode = 0; m_row = 0; m_dwell = 0; m_run = 0;
            cand_row = 0; cand_col = 0; key_row = 0; key_col = 0;
            has_key = 0; m_held = 0;
            return;
        end
        if (m_mode == 0) begin
            m_dwell++;
            if (m_dwell == SC) begin
                m_dwell = 0;
                if ($countones(cs) == 1) begin
                    cand_row = m_row; cand_col = col_index(cs);
                    m_run = 0; m_mode = 1;
                end else begin
                    m_row = (m_row + 1) % 4;
                end
            end
        end else if (m_mode == 1) begin
            if (cs != 4'(1 << cand_col)) begin
                m_mode = 0; m_row = (m_row + 1) % 4; m_dwell = 0;
            end else begin
                m_run++;
                if (m_run == DB) begin
                    key_row = cand_row; key_col = cand_col; has_key = 1; m_held = 1; m_mode = 2;
                    exp_q.push_back('{r: 4'(1 << key_row), c: 4'(1 << key_col), t: $time + P});
                end
            end
        end else if (m_mode == 2) begin
            if (!cs[key_col]) begin m_run = 0; m_mode = 3; end
        end else begin
            if (cs[key_col]) m_mode = 2;
            else begin
                m_run++;
                if (m_run == DB) begin
                    m_held = 0; m_mode = 0; m_row = (m_row + 1) % 4; m_dwell = 0;
                end
            end
        end
    endtask

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    // Called at a falling edge: compare, choose inputs for the next rising edge, advance the model
    task automatic cycle();
        logic [3:0] c;
        check("rows", rows, 4'(1 << m_row));
        check("key_held", {3'd0, key_held}, {3'd0, m_held});
        check("key_rows", key_rows, has_key ? 4'(1 << key_row) : 4'd0);
        check("key_cols", key_cols, has_key ? 4'(1 << key_col) : 4'd0);
        c = 4'd0;
        for (int r = 0; r < 4; r++) if (rows[r]) c |= pressed[r*4 +: 4];
        if (glitch > 0) begin c = 4'd0; glitch--; end
        cols_raw = c;
        step_model(reset, c);
        @(negedge clk);
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic wait_mode(input int m, input int lim);
        int k = 0;
        while (m_mode != m && k < lim) begin cycle(); k++; end
        n_cmp++;
        if (m_mode != m) begin
            n_fail++;
            $display("FAIL wait_mode: model state %0d expected %0d after %0d cycles", m_mode, m, lim);
        end
    endtask

    always @(negedge clk) begin
        if (key_valid !== 1'b0) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL key_valid_unexpected at %0t: got %b expected no pulse", $time, key_valid);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                check("valid_key_rows", key_rows, e.r);
                check("valid_key_cols", key_cols, e.c);
                n_cmp++;
                if ($time != e.t) begin
                    n_fail++;
                    $display("FAIL valid_time: got %0t expected %0t", $time, e.t);
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        step_model(1'b1, 4'd0);
        @(negedge clk);
        run(3);
        reset = 1'b0;
        run(40);

        pressed = 16'd1 << (2*4 + 1);
        run(60);
        pressed = 16'd0;
        run(30);

        pressed = 16'd1 << (1*4 + 2);
        wait_mode(1, 40);
        run(2);
        glitch = 1;
        wait_mode(2, 60);
        run(5);
        glitch = 3;
        run(20);
        pressed = 16'd0;
        run(25);

        pressed = (16'd1 << (1*4 + 0)) | (16'd1 << (1*4 + 3));
        run(40);
        pressed = 16'd1 << (3*4 + 0);
        wait_mode(2, 60);
        pressed |= (16'd1 << (3*4 + 2)) | (16'd1 << (0*4 + 1));
        run(30);
        pressed = 16'd0;
        run(25);

        pressed = 16'd1 << (0*4 + 3);
        wait_mode(2, 60);
        run(3);
        reset = 1'b1;
        run(1);
        reset = 1'b0;
        pressed = 16'd0;
        run(30);

        for (int s = 0; s < 40; s++) begin
            int nk, dur;
            pressed = 16'd0;
            nk = $urandom_range(0, 2);
            for (int k = 0; k < nk; k++) pressed |= 16'd1 << $urandom_range(0, 15);
            dur = $urandom_range(5, 90);
            for (int i = 0; i < dur; i++) begin
                if ($urandom_range(0, 24) == 0) glitch = $urandom_range(1, 3);
                reset = ($urandom_range(0, 199) == 0);
                cycle();
            end
            reset = 1'b0;
            pressed = 16'd0;
            run($urandom_range(0, 30));
        end

        pressed = 16'd0;
        run(30);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL missing_key_valid: %0d expected pulses never seen", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 The module SHALL have parameter SCAN_CYCLES, default 4, setting the number of clock cycles each row is driven during scanning (legal range 3 to 2^16).
REQ-002 The module SHALL have parameter DEBOUNCE_CYCLES, default 8, setting the number of consecutive stable cycles needed to accept a press or a release (legal range 1 to 2^16).
REQ-003 clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 cols_raw  input  4  asynchronous keypad column levels, active-high, bit i = column i.
REQ-006 rows  output  4  one-hot active-high row drive to the keypad.
REQ-007 key_rows  output  4  one-hot row of the accepted key, for the key decoder.
REQ-008 key_cols  output  4  one-hot column of the accepted key, for the key decoder.
REQ-009 key_valid  output  1  one-cycle pulse marking a new accepted press.
REQ-010 key_held  output  1  high while an accepted key remains pressed, including through its release debounce.

Function
REQ-011 cols_raw SHALL pass through a two-flop synchronizer; cols_s denotes the second flop output, and all logic below SHALL use only cols_s.
REQ-012 The FSM SHALL have four states: SCAN, PRESS_DB, HELD and RELEASE_DB.
REQ-013 In SCAN, a dwell counter SHALL count 0..SCAN_CYCLES-1; at count SCAN_CYCLES-1, rows SHALL rotate left (0001->0010->0100->1000->0001) and the counter SHALL clear.
REQ-014 In SCAN, at dwell count SCAN_CYCLES-1, if cols_s is exactly one-hot:
- cand_rows SHALL capture the current rows and cand_cols SHALL capture cols_s.
- the FSM SHALL enter PRESS_DB with rows held and the debounce counter cleared.
REQ-015 In SCAN, a cols_s value of zero or with two or more bits set at the sample point SHALL be ignored and scanning SHALL continue.
REQ-016 In PRESS_DB, rows SHALL stay frozen; each cycle with cols_s == cand_cols SHALL increment the debounce counter.
REQ-017 In PRESS_DB, any cycle with cols_s != cand_cols SHALL return the FSM to SCAN, rotating rows to the next row with the dwell counter cleared, and SHALL produce no key_valid.
REQ-018 In PRESS_DB, a matching cycle at debounce count DEBOUNCE_CYCLES-1 SHALL cause all of the following on the next edge:
- transition to HELD.
- key_rows <= cand_rows and key_cols <= cand_cols.
- key_valid high for exactly that one cycle.
- key_held high.
REQ-019 In HELD, rows SHALL stay frozen; additional presses in other columns SHALL be ignored; when (cols_s & key_cols) == 0 the FSM SHALL enter RELEASE_DB with the debounce counter cleared.
REQ-020 In RELEASE_DB, each cycle with (cols_s & key_cols) == 0 SHALL increment the counter; any cycle with the key column high SHALL return the FSM to HELD with no new key_valid.
REQ-021 In RELEASE_DB, a released cycle at count DEBOUNCE_CYCLES-1 SHALL clear key_held and move to SCAN, rotating rows to the next row.
REQ-022 key_rows and key_cols SHALL hold the last accepted key after release until the next acceptance.
REQ-023 key_valid SHALL be asserted at most once per physical press, and never in the same cycle as reset.
REQ-024 Accept latency SHALL be exactly DEBOUNCE_CYCLES cycles from entry into PRESS_DB to key_valid, given a stable input.

Reset
REQ-025 While reset is high, the module SHALL set state=SCAN, rows=0001, key_rows=0000, key_cols=0000, key_valid=0, key_held=0, clear all counters and synchronizer flops, and discard any candidate.
REQ-026 Reset asserted in any state, including mid-debounce or HELD, SHALL take effect on the next edge; after reset deasserts, scanning SHALL restart from row 0001 with the dwell counter at 0.

Verification (SCAN_CYCLES=4, DEBOUNCE_CYCLES=8)
REQ-027 Reset, no keys: rows SHALL cycle 0001,0010,0100,1000 with 4 cycles each, and key_valid SHALL never assert.
REQ-028 Hold the key at row 0100/col 0010 steady: exactly one key_valid pulse SHALL occur, with key_rows=0100 and key_cols=0010, 8 cycles after PRESS_DB entry; key_held SHALL stay 1 while pressed and fall 8 cycles after release; scanning SHALL then resume at rows=1000.
REQ-029 Bounce the column low for 1 cycle during PRESS_DB: the FSM SHALL return to SCAN with no key_valid, and the key SHALL be re-detected on its row's next dwell.
REQ-030 Glitch the key column low for 3 cycles during HELD: the FSM SHALL pass through RELEASE_DB and back to HELD, with no second key_valid and key_held staying 1.
REQ-031 Press two columns at once on one row: the pair SHALL be ignored and scanning SHALL continue; pressing a second key while HELD SHALL produce no key_valid.
REQ-032 Assert reset during HELD: the next cycle SHALL show rows=0001, key_held=0, key_cols=0000.
